// File: rtl/time_set_editor_if.sv
// Port bundle for time_set_editor: mode and key inputs plus the running-clock snapshot in;
// the edited time, cursor, editing flag and commit strobe out.
interface time_set_editor_if;
  logic [3:0] MODE;
  logic [3:0] NUM_SYNC;
  logic [1:0] NUM_HELD;
  logic       CUR_MERIDIEM;
  logic [6:0] CUR_HOUR;
  logic [6:0] CUR_MIN;
  logic [6:0] CUR_SEC;
  logic [2:0] CURSOR;
  logic       MERIDIEM;
  logic [6:0] HOUR;
  logic [6:0] MIN;
  logic [6:0] SEC;
  logic       EDITING;
  logic       COMMIT;

  modport master (
    output MODE, NUM_SYNC, NUM_HELD, CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC,
    input  CURSOR, MERIDIEM, HOUR, MIN, SEC, EDITING, COMMIT
  );

  modport slave (
    input  MODE, NUM_SYNC, NUM_HELD, CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC,
    output CURSOR, MERIDIEM, HOUR, MIN, SEC, EDITING, COMMIT
  );
endinterface

// File: rtl/time_set_editor.sv
// Cursor-driven HH:MM:SS digit editor with key auto-repeat; loads the running time on mode
// entry and strobes COMMIT for one cycle on mode exit. Key effects appear one edge later.
module time_set_editor #(
  parameter int         HOUR_24       = 0,
  parameter logic [3:0] MODE_ID       = 4'b0000,
  parameter int         REPEAT_START  = 50,
  parameter int         REPEAT_PERIOD = 10,
  parameter int         RPT_W         = 8
) (
  input logic              CLK,
  input logic              RESET,
  time_set_editor_if.slave bus
);

  localparam logic [6:0]       HMIN       = (HOUR_24 != 0) ? 7'd0  : 7'd1;
  localparam logic [6:0]       HMAX       = (HOUR_24 != 0) ? 7'd23 : 7'd12;
  localparam logic [2:0]       NPOS_LAST  = (HOUR_24 != 0) ? 3'd5  : 3'd6;
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_START - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_START - REPEAT_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_editing;
  logic             w_commit;
  logic [2:0]       r_cursor;
  logic             r_mer;
  logic [6:0]       r_hour;
  logic [6:0]       r_min;
  logic [6:0]       r_sec;
  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] w_rpt_nxt;
  logic             w_tick;
  logic             w_active;
  logic             w_press;
  logic             w_up;
  logic             w_dn;
  logic             w_step;
  logic             w_step_up;
  logic             w_right;
  logic             w_left;

  function automatic logic [6:0] f_ms(input logic [6:0] v, input logic tens, input logic up);
    logic [6:0] ones;
    ones = v % 7'd10;
    if (!tens)
      f_ms = up ? ((ones == 7'd9) ? v - 7'd9 : v + 7'd1)
                : ((ones == 7'd0) ? v + 7'd9 : v - 7'd1);
    else
      f_ms = up ? ((v >= 7'd50) ? v - 7'd50 : v + 7'd10)
                : ((v < 7'd10)  ? v + 7'd50 : v - 7'd10);
  endfunction

  function automatic logic [6:0] f_hour(input logic [6:0] v, input logic tens, input logic up);
    logic [6:0] ones;
    ones = v % 7'd10;
    if (!tens)
      f_hour = up ? ((v == HMAX) ? HMIN : v + 7'd1)
                  : ((v == HMIN) ? HMAX : v - 7'd1);
    else if (up)
      f_hour = (v + 7'd10 <= HMAX) ? v + 7'd10
             : ((HOUR_24 == 0) && (ones == 7'd0)) ? HMIN : ones;
    else if (v >= HMIN + 7'd10) f_hour = v - 7'd10;
    else if (v + 7'd20 <= HMAX) f_hour = v + 7'd20;
    else if (v + 7'd10 <= HMAX) f_hour = v + 7'd10;
    else                        f_hour = v;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_editing   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.MODE == MODE_ID) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_EDIT;
      S_EDIT: begin
        w_editing = 1'b1;
        if (bus.MODE != MODE_ID) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Keys only act while editing and staying in the mode; the exit cycle drops them.
  assign w_active = (r_state == S_EDIT) && (bus.MODE == MODE_ID);
  assign w_press  = bus.NUM_SYNC[0] | bus.NUM_SYNC[1];

  always_comb begin
    w_tick    = 1'b0;
    w_rpt_nxt = '0;
    if (w_active && !w_press && (bus.NUM_HELD[0] ^ bus.NUM_HELD[1])) begin
      if (r_rpt == RPT_LAST) begin
        w_tick    = 1'b1;
        w_rpt_nxt = RPT_RELOAD;
      end else begin
        w_rpt_nxt = r_rpt + 1'b1;
      end
    end
  end

  assign w_up      = w_active && (bus.NUM_SYNC[0] || (w_tick && bus.NUM_HELD[0]));
  assign w_dn      = w_active && (bus.NUM_SYNC[1] || (w_tick && bus.NUM_HELD[1]));
  assign w_step    = w_up ^ w_dn;
  assign w_step_up = w_up;
  assign w_right   = w_active && bus.NUM_SYNC[2] && !bus.NUM_SYNC[3];
  assign w_left    = w_active && bus.NUM_SYNC[3] && !bus.NUM_SYNC[2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cursor <= 3'd0;
      r_mer    <= 1'b0;
      r_hour   <= HMIN;
      r_min    <= 7'd0;
      r_sec    <= 7'd0;
      r_rpt    <= '0;
    end else begin
      r_rpt <= w_rpt_nxt;
      if (r_state == S_LOAD) begin
        r_cursor <= 3'd0;
        r_mer    <= (HOUR_24 != 0) ? 1'b0 : bus.CUR_MERIDIEM;
        r_hour   <= ((bus.CUR_HOUR > HMAX) || ((HOUR_24 == 0) && (bus.CUR_HOUR == 7'd0)))
                    ? HMIN : bus.CUR_HOUR;
        r_min    <= (bus.CUR_MIN > 7'd59) ? 7'd0 : bus.CUR_MIN;
        r_sec    <= (bus.CUR_SEC > 7'd59) ? 7'd0 : bus.CUR_SEC;
      end else begin
        // The step targets the pre-move cursor; the cursor update lands on the same edge.
        if (w_step) begin
          case (r_cursor)
            3'd0:    r_sec  <= f_ms(r_sec, 1'b0, w_step_up);
            3'd1:    r_sec  <= f_ms(r_sec, 1'b1, w_step_up);
            3'd2:    r_min  <= f_ms(r_min, 1'b0, w_step_up);
            3'd3:    r_min  <= f_ms(r_min, 1'b1, w_step_up);
            3'd4:    r_hour <= f_hour(r_hour, 1'b0, w_step_up);
            3'd5:    r_hour <= f_hour(r_hour, 1'b1, w_step_up);
            3'd6:    if (HOUR_24 == 0) r_mer <= ~r_mer;
            default: ;
          endcase
        end
        if (w_right)     r_cursor <= (r_cursor == NPOS_LAST) ? 3'd0 : r_cursor + 3'd1;
        else if (w_left) r_cursor <= (r_cursor == 3'd0) ? NPOS_LAST : r_cursor - 3'd1;
      end
    end
  end

  assign bus.CURSOR   = r_cursor;
  assign bus.MERIDIEM = r_mer;
  assign bus.HOUR     = r_hour;
  assign bus.MIN      = r_min;
  assign bus.SEC      = r_sec;
  assign bus.EDITING  = w_editing;
  assign bus.COMMIT   = w_commit;

endmodule
